dmem_bus_arbiter: RTL and testbench
===================================

// Module: dmem_bus_arbiter
// PURPOSE
//  Shares the single data-memory/peripheral bus between NUM_MST masters: the MiniRISC CPU (master 0),
//  a DMA engine and the debug master. Round-robin arbitration runs on the req/grant handshake.
//  Ownership is held for as long as the owner keeps req high, so CPU stack push/pop sequences stay atomic.
//  The block merges the granted master's addr/wr/rd/wdata onto the slave bus.
//  A watchdog counts owner tenure and flags hogging.
// PARAMETERS
//  NUM_MST    2    number of masters, 2..4; index 0 has highest priority after reset
//  ADDR_W     8    address width
//  DATA_W     8    write-data width
//  HOLD_MAX   64   tenure cycles with others waiting before hold_err sets; 1..255
// PORTS
//  clk        in   1               system clock, rising edge
//  rst        in   1               asynchronous, active-low reset
//  mst_req    in   NUM_MST         per-master bus request, level
//  mst_grant  out  NUM_MST         per-master grant, registered, one-hot or zero
//  mst_addr   in   NUM_MST*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
//  mst_wr     in   NUM_MST         write strobes
//  mst_rd     in   NUM_MST         read strobes
//  mst_wdata  in   NUM_MST*DATA_W  packed write data
//  slv_addr   out  ADDR_W          merged address bus
//  slv_wr     out  1               merged write strobe
//  slv_rd     out  1               merged read strobe
//  slv_wdata  out  DATA_W          merged write data
//  owner      out  2               index of granted master; valid only while busy=1
//  busy       out  1               some master holds the bus
//  hold_err   out  1               sticky watchdog flag
//  err_clr    in   1               clears hold_err, one-cycle pulse
// BEHAVIOUR
//  - Reset (rst=0, async): mst_grant=0, busy=0, owner=0, hold_err=0, tenure=0, rr_ptr=0. All slv_* outputs are 0.
//  - FSM with two states:
//    - IDLE: if any req, grant the first requester scanning from rr_ptr upward (mod NUM_MST) -> GRANT.
//      The grant is visible the cycle after req is sampled (1-cycle latency).
//    - GRANT: while mst_req[owner]=1, hold the grant; other requests wait.
//      When mst_req[owner] is sampled 0:
//      - rr_ptr <= owner+1 (mod NUM_MST).
//      - If other reqs are pending, grant the next one from the new rr_ptr on the same edge, then stay in GRANT with zero dead cycles.
//      - Otherwise drop the grant and go to IDLE.
//  - Grant is never revoked while req stays high. Hogging only raises hold_err.
//  - A master that drops and re-raises req in consecutive cycles while others wait goes behind them in rotation.
//  - Simultaneous requests in IDLE are resolved by rr_ptr order. After reset, master 0 wins.
//  - Slave bus outputs are combinational: slv_* = signals of the owner when busy, else 0.
//    wr/rd/addr/wdata of non-granted masters are ignored.
//  - Watchdog:
//    - tenure clears on every grant change and counts cycles in GRANT while any other req=1. It saturates at 255.
//    - When tenure reaches HOLD_MAX, hold_err <= 1.
//    - err_clr takes priority over a set in the same cycle.
//  - The owner index is 2 bits wide for all NUM_MST. Index values >= NUM_MST never occur.
//    Unused req bits are ignored by construction.
// STRUCTURE
//  - Shared header dmem_bus_arbiter_defs.vh holds the state encodings ARB_IDLE/ARB_GRANT and the default HOLD_MAX.
//  - One sub-module, rr_pick: combinational. Inputs req vector and rr_ptr; outputs the next index and a found bit.
//    It is reused by the future peripheral-bus arbiter.
//  - Top level holds the FSM, the rr_ptr/owner/tenure registers and the merge mux.
// TESTING
//  1 Reset with all inputs 0, then release -> grant=0, busy=0, slv_*=0, hold_err=0.
//  2 NUM_MST=2, req=2'b11 in the same cycle from reset -> next cycle grant=01, owner=0.
//    Drop req0 -> the following cycle grant=10 with no gap.
//  3 CPU holds req0 for 5 cycles (stack push) while req1=1 -> grant stays 01 for all 5 cycles.
//    Master 1 is granted on the cycle after req0 falls.
//  4 Owner=1 with addr=8'h80, wr=1, wdata=8'hA5, while master 0 drives addr=8'h10, wr=1
//    -> slv_addr=80, slv_wr=1, slv_wdata=A5.
//  5 HOLD_MAX=4: owner holds while another req waits -> hold_err=1 after exactly 4 waiting cycles.
//    err_clr clears it; a set in the same cycle as err_clr leaves it 0.
//  6 Assert rst mid-tenure -> grant, busy and slv_* go 0 asynchronously.
//    After release, rr_ptr=0 and master 0 wins the tie.

Source files
------------

// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory bus arbiter: FSM state encodings,
// the default watchdog limit and the modular index arithmetic used by the
// round-robin picker and the pointer update.
package dmem_bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int HOLD_MAX_DEFAULT = 64;

    // (base + ofs) mod n, assuming base < n and ofs < n
    function automatic logic [1:0] wrap_add(input logic [1:0] base, input int ofs, input int n);
        int t;
        t = int'(base) + ofs;
        if (t >= n) begin
            t = t - n;
        end
        return t[1:0];
    endfunction

endpackage

// File: rtl/dmem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req_i starting at ptr_i and wrapping
// modulo NUM_MST, returning the first requester found. Kept free of arbiter
// state so other bus arbiters can share it.
module dmem_bus_arbiter_rr_pick
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int NUM_MST = 2
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [1:0]         idx_o,
    output logic               found_o
);

    logic [1:0]         cand;
    logic [NUM_MST-1:0] req_sh;

    // Scan from the farthest offset down so the candidate closest to ptr_i wins last
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        req_sh  = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            cand   = wrap_add(ptr_i, k, NUM_MST);
            req_sh = req_i >> cand;
            if (req_sh[0]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Data-memory/peripheral bus arbiter. Masters request with a level req and
// keep ownership for as long as req stays high, which keeps CPU push/pop
// sequences atomic. Hand-over between masters is round-robin and happens on
// the same edge the owner releases, so there is no dead cycle. The granted
// master's strobes and data are merged onto the slave bus combinationally.
// A tenure watchdog flags an owner that holds the bus while others wait.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ARB_IDLE  | nobody owns the bus; any request is granted next edge
//   ARB_GRANT | owner_q holds the bus until its req is sampled low
module dmem_bus_arbiter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int NUM_MST  = 2,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MST-1:0]        mst_req,
    output logic [NUM_MST-1:0]        mst_grant,
    input  logic [NUM_MST*ADDR_W-1:0] mst_addr,
    input  logic [NUM_MST-1:0]        mst_wr,
    input  logic [NUM_MST-1:0]        mst_rd,
    input  logic [NUM_MST*DATA_W-1:0] mst_wdata,
    output logic [ADDR_W-1:0]         slv_addr,
    output logic                      slv_wr,
    output logic                      slv_rd,
    output logic [DATA_W-1:0]         slv_wdata,
    output logic [1:0]                owner,
    output logic                      busy,
    output logic                      hold_err,
    input  logic                      err_clr
);

    localparam logic [7:0] TENURE_HOLD = 8'(HOLD_MAX);
    localparam logic [7:0] TENURE_SAT  = 8'hFF;

    arb_state_e         state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_MST-1:0] grant_q, grant_d;
    logic [7:0]         tenure_q, tenure_d;
    logic               hold_err_q, hold_err_d;

    logic [1:0]         pick_ptr;
    logic [1:0]         pick_idx;
    logic               pick_found;
    logic [NUM_MST-1:0] pick_onehot;
    logic               owner_req;
    logic               others_wait;
    logic               tenure_reached;

    // grant_q is one-hot of owner_q whenever busy, so masking by it selects the owner
    assign owner_req   = |(mst_req & grant_q);
    assign others_wait = |(mst_req & ~grant_q);

    // On release the scan restarts just past the owner; the owner's own req is
    // already low, so it naturally falls behind anyone still waiting
    assign pick_ptr = (state_q == ARB_GRANT) ? wrap_add(owner_q, 1, NUM_MST) : rr_ptr_q;

    dmem_bus_arbiter_rr_pick #(
        .NUM_MST (NUM_MST)
    ) u_rr_pick (
        .req_i   (mst_req),
        .ptr_i   (pick_ptr),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Decode the picked index into a grant vector
    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            pick_onehot[i] = (pick_idx == 2'(i));
        end
    end

    // Next-state logic: arbitration, round-robin pointer and tenure counter
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        tenure_d = tenure_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_onehot;
                    owner_d  = pick_idx;
                    tenure_d = '0;
                    state_d  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (owner_req) begin
                    if (others_wait && (tenure_q != TENURE_SAT)) begin
                        tenure_d = tenure_q + 8'd1;
                    end
                end else begin
                    rr_ptr_d = pick_ptr;
                    tenure_d = '0;
                    if (pick_found) begin
                        grant_d = pick_onehot;
                        owner_d = pick_idx;
                    end else begin
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Sticky hog flag: set on the edge tenure arrives at the limit, clear wins
    always_comb begin
        tenure_reached = (tenure_d == TENURE_HOLD) && (tenure_q != TENURE_HOLD);
        hold_err_d     = hold_err_q;
        if (tenure_reached) begin
            hold_err_d = 1'b1;
        end
        if (err_clr) begin
            hold_err_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            tenure_q   <= '0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            tenure_q   <= tenure_d;
            hold_err_q <= hold_err_d;
        end
    end

    // Merge the owner's signals onto the slave bus; zero when nobody is granted
    always_comb begin
        slv_addr  = '0;
        slv_wr    = 1'b0;
        slv_rd    = 1'b0;
        slv_wdata = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant_q[i]) begin
                slv_addr  = mst_addr[i*ADDR_W +: ADDR_W];
                slv_wr    = mst_wr[i];
                slv_rd    = mst_rd[i];
                slv_wdata = mst_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign mst_grant = grant_q;
    assign owner     = owner_q;
    assign busy      = (state_q == ARB_GRANT);
    assign hold_err  = hold_err_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter with two masters and a short watchdog limit.
module tb_dmem_bus_arbiter;

    localparam int NUM_MST  = 2;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int HOLD_MAX = 4;

    logic                      clk;
    logic                      rst;
    logic [NUM_MST-1:0]        mst_req;
    logic [NUM_MST-1:0]        mst_grant;
    logic [NUM_MST*ADDR_W-1:0] mst_addr;
    logic [NUM_MST-1:0]        mst_wr;
    logic [NUM_MST-1:0]        mst_rd;
    logic [NUM_MST*DATA_W-1:0] mst_wdata;
    logic [ADDR_W-1:0]         slv_addr;
    logic                      slv_wr;
    logic                      slv_rd;
    logic [DATA_W-1:0]         slv_wdata;
    logic [1:0]                owner;
    logic                      busy;
    logic                      hold_err;
    logic                      err_clr;

    int n_cmp;
    int n_mis;

    dmem_bus_arbiter #(
        .NUM_MST  (NUM_MST),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mst_req   (mst_req),
        .mst_grant (mst_grant),
        .mst_addr  (mst_addr),
        .mst_wr    (mst_wr),
        .mst_rd    (mst_rd),
        .mst_wdata (mst_wdata),
        .slv_addr  (slv_addr),
        .slv_wr    (slv_wr),
        .slv_rd    (slv_rd),
        .slv_wdata (slv_wdata),
        .owner     (owner),
        .busy      (busy),
        .hold_err  (hold_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        mst_req   = '0;
        mst_addr  = '0;
        mst_wr    = '0;
        mst_rd    = '0;
        mst_wdata = '0;
        err_clr   = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        n_cmp++; if (mst_grant !== 2'b00) begin n_mis++; $display("FAIL reset_grant: got %b want 00", mst_grant); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({slv_addr, slv_wr, slv_rd, slv_wdata} !== 18'h0) begin n_mis++; $display("FAIL reset_slv: got %h/%b/%b/%h want all 0", slv_addr, slv_wr, slv_rd, slv_wdata); end
        n_cmp++; if (hold_err !== 1'b0) begin n_mis++; $display("FAIL reset_hold_err: got %b want 0", hold_err); end
    endtask

    task automatic test_tie_and_handover();
        apply_reset();
        mst_req = 2'b11;
        step();
        n_cmp++; if (mst_grant !== 2'b01) begin n_mis++; $display("FAIL tie_grant: got %b want 01", mst_grant); end
        n_cmp++; if (owner !== 2'd0 || busy !== 1'b1) begin n_mis++; $display("FAIL tie_owner: got owner %0d busy %b want 0/1", owner, busy); end
        mst_req = 2'b10;
        step();
        n_cmp++; if (mst_grant !== 2'b10) begin n_mis++; $display("FAIL handover_grant: got %b want 10", mst_grant); end
        n_cmp++; if (owner !== 2'd1 || busy !== 1'b1) begin n_mis++; $display("FAIL handover_owner: got owner %0d busy %b want 1/1", owner, busy); end
        mst_req = 2'b00;
        step();
        n_cmp++; if (mst_grant !== 2'b00 || busy !== 1'b0) begin n_mis++; $display("FAIL release_idle: got grant %b busy %b want 00/0", mst_grant, busy); end
    endtask

    task automatic test_atomic_hold();
        apply_reset();
        mst_req = 2'b11;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++; if (mst_grant !== 2'b01) begin n_mis++; $display("FAIL hold_cycle%0d: got %b want 01", c, mst_grant); end
        end
        mst_req = 2'b10;
        step();
        n_cmp++; if (mst_grant !== 2'b10 || owner !== 2'd1) begin n_mis++; $display("FAIL hold_release: got grant %b owner %0d want 10/1", mst_grant, owner); end
    endtask

    task automatic test_merge();
        // continues with master 1 owning the bus
        mst_addr  = {8'h80, 8'h10};
        mst_wr    = 2'b11;
        mst_rd    = 2'b01;
        mst_wdata = {8'hA5, 8'h5A};
        #1;
        n_cmp++; if (slv_addr !== 8'h80) begin n_mis++; $display("FAIL merge_addr: got %h want 80", slv_addr); end
        n_cmp++; if (slv_wr !== 1'b1 || slv_rd !== 1'b0) begin n_mis++; $display("FAIL merge_strobes: got wr %b rd %b want 1/0", slv_wr, slv_rd); end
        n_cmp++; if (slv_wdata !== 8'hA5) begin n_mis++; $display("FAIL merge_wdata: got %h want a5", slv_wdata); end
        mst_req = 2'b00;
        step();
        n_cmp++; if ({slv_addr, slv_wr, slv_rd, slv_wdata} !== 18'h0) begin n_mis++; $display("FAIL merge_idle: got %h/%b/%b/%h want all 0", slv_addr, slv_wr, slv_rd, slv_wdata); end
        mst_addr  = '0;
        mst_wr    = '0;
        mst_rd    = '0;
        mst_wdata = '0;
    endtask

    task automatic test_watchdog();
        apply_reset();
        mst_req = 2'b11;
        step();
        for (int c = 1; c <= 3; c++) begin
            step();
            n_cmp++; if (hold_err !== 1'b0) begin n_mis++; $display("FAIL wd_early%0d: got %b want 0", c, hold_err); end
        end
        step();
        n_cmp++; if (hold_err !== 1'b1) begin n_mis++; $display("FAIL wd_set: got %b want 1", hold_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_cmp++; if (hold_err !== 1'b0) begin n_mis++; $display("FAIL wd_clear: got %b want 0", hold_err); end
        // hand over to master 1, then let master 0 wait again
        mst_req = 2'b10;
        step();
        n_cmp++; if (mst_grant !== 2'b10) begin n_mis++; $display("FAIL wd_handover: got %b want 10", mst_grant); end
        mst_req = 2'b11;
        step();
        step();
        step();
        n_cmp++; if (hold_err !== 1'b0) begin n_mis++; $display("FAIL wd_second_early: got %b want 0", hold_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_cmp++; if (hold_err !== 1'b0) begin n_mis++; $display("FAIL wd_clr_priority: got %b want 0", hold_err); end
        mst_req = 2'b00;
        step();
    endtask

    task automatic test_async_reset();
        apply_reset();
        mst_req = 2'b01;
        step();
        mst_req = 2'b00;
        step();
        // rr pointer now points at master 1; give master 1 the bus with master 0 waiting
        mst_req   = 2'b10;
        step();
        mst_req   = 2'b11;
        mst_addr  = {8'h44, 8'h33};
        mst_wr    = 2'b10;
        mst_wdata = {8'hC3, 8'h3C};
        step();
        n_cmp++; if (mst_grant !== 2'b10 || slv_addr !== 8'h44) begin n_mis++; $display("FAIL ar_pre: got grant %b addr %h want 10/44", mst_grant, slv_addr); end
        #3;
        rst = 1'b0;
        #1;
        n_cmp++; if (mst_grant !== 2'b00 || busy !== 1'b0) begin n_mis++; $display("FAIL ar_async: got grant %b busy %b want 00/0", mst_grant, busy); end
        n_cmp++; if ({slv_addr, slv_wr, slv_rd, slv_wdata} !== 18'h0) begin n_mis++; $display("FAIL ar_slv: got %h/%b/%b/%h want all 0", slv_addr, slv_wr, slv_rd, slv_wdata); end
        step();
        rst = 1'b1;
        step();
        n_cmp++; if (mst_grant !== 2'b01 || owner !== 2'd0) begin n_mis++; $display("FAIL ar_tie: got grant %b owner %0d want 01/0", mst_grant, owner); end
        mst_req = 2'b00;
        step();
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        rst       = 1'b0;
        mst_req   = '0;
        mst_addr  = '0;
        mst_wr    = '0;
        mst_rd    = '0;
        mst_wdata = '0;
        err_clr   = 1'b0;
        test_reset();
        test_tie_and_handover();
        test_atomic_hold();
        test_merge();
        test_watchdog();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
